// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, mul/div and AES
// results are buffered and drained round-robin, with a pending bitmap and starvation hold.
package rf_wb_arbiter_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;
endpackage

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic        aes_valid,
    output logic        aes_ready,
    input  logic [4:0]  aes_rd,
    input  logic [31:0] aes_data,
    input  logic        issue_set,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending,
    output logic        rs_hazard,
    output logic        hold_pipe
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 4;

    wb_entry_t        mdu_mem [FIFO_DEPTH];
    wb_entry_t        aes_mem [FIFO_DEPTH];
    logic [AW-1:0]    mdu_wptr, mdu_rptr, aes_wptr, aes_rptr;
    logic [CW-1:0]    mdu_cnt, aes_cnt;
    logic             last_mdu;          // 1: mul/div was served last
    logic [SW-1:0]    starve_cnt;

    logic             mdu_push, aes_push, mdu_pop, aes_pop;
    logic             mdu_empty, aes_empty, pipe_win, any_pop, commit;
    wb_entry_t        pop_entry;
    logic [31:0]      pend_set, pend_clr, pending_nxt;
    logic [SW-1:0]    starve_nxt;

    assign mdu_ready = (mdu_cnt != CW'(FIFO_DEPTH));
    assign aes_ready = (aes_cnt != CW'(FIFO_DEPTH));
    assign mdu_push  = mdu_valid && mdu_ready;
    assign aes_push  = aes_valid && aes_ready;
    assign mdu_empty = (mdu_cnt == '0);
    assign aes_empty = (aes_cnt == '0);

    assign rs_hazard = pending[rs1] | pending[rs2];
    assign hold_pipe = (starve_cnt >= SW'(STARVE_LIMIT));

    // Grant, pending and starvation next-state
    always_comb begin
        pipe_win   = pipe_we && (pipe_rd != '0);
        mdu_pop    = 1'b0;
        aes_pop    = 1'b0;
        pop_entry  = aes_mem[aes_rptr];
        pend_set   = '0;
        pend_clr   = '0;
        starve_nxt = starve_cnt;

        if (!pipe_win) begin
            if (!mdu_empty && (aes_empty || !last_mdu)) begin
                mdu_pop = 1'b1;
            end else if (!aes_empty) begin
                aes_pop = 1'b1;
            end
        end
        if (mdu_pop) begin
            pop_entry = mdu_mem[mdu_rptr];
        end

        any_pop = mdu_pop || aes_pop;
        commit  = any_pop && (pop_entry.rd != '0);

        if (commit) begin
            pend_clr = 32'(1) << pop_entry.rd;
        end
        if (issue_set && (issue_rd != '0)) begin
            pend_set = 32'(1) << issue_rd;
        end
        pending_nxt = (pending & ~pend_clr) | pend_set;

        if (any_pop || (mdu_empty && aes_empty)) begin
            starve_nxt = '0;
        end else if (pipe_win && (starve_cnt < SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // Buffer storage carries no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (mdu_push) begin
            mdu_mem[mdu_wptr] <= '{rd: mdu_rd, data: mdu_data};
        end
        if (aes_push) begin
            aes_mem[aes_wptr] <= '{rd: aes_rd, data: aes_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mdu_wptr   <= '0;
            mdu_rptr   <= '0;
            mdu_cnt    <= '0;
            aes_wptr   <= '0;
            aes_rptr   <= '0;
            aes_cnt    <= '0;
            last_mdu   <= 1'b0;
            starve_cnt <= '0;
            pending    <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            if (mdu_push) mdu_wptr <= mdu_wptr + AW'(1);
            if (mdu_pop)  mdu_rptr <= mdu_rptr + AW'(1);
            if (aes_push) aes_wptr <= aes_wptr + AW'(1);
            if (aes_pop)  aes_rptr <= aes_rptr + AW'(1);

            case ({mdu_push, mdu_pop})
                2'b10:   mdu_cnt <= mdu_cnt + CW'(1);
                2'b01:   mdu_cnt <= mdu_cnt - CW'(1);
                default: mdu_cnt <= mdu_cnt;
            endcase
            case ({aes_push, aes_pop})
                2'b10:   aes_cnt <= aes_cnt + CW'(1);
                2'b01:   aes_cnt <= aes_cnt - CW'(1);
                default: aes_cnt <= aes_cnt;
            endcase

            if (mdu_pop) begin
                last_mdu <= 1'b1;
            end else if (aes_pop) begin
                last_mdu <= 1'b0;
            end

            starve_cnt <= starve_nxt;
            pending    <= pending_nxt;

            if (pipe_win) begin
                rf_we    <= 1'b1;
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (commit) begin
                rf_we    <= 1'b1;
                rf_waddr <= pop_entry.rd;
                rf_wdata <= pop_entry.data;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the write-port arbitration rules.
module tb_rf_wb_arbiter;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        aes_valid, aes_ready;
    logic [4:0]  aes_rd;
    logic [31:0] aes_data;
    logic        issue_set;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pending;
    logic        rs_hazard, hold_pipe;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .nrst(nrst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .aes_valid(aes_valid), .aes_ready(aes_ready), .aes_rd(aes_rd), .aes_data(aes_data),
        .issue_set(issue_set), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .rs_hazard(rs_hazard), .hold_pipe(hold_pipe)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        aq[$];
    logic [31:0] m_pend;
    int          m_starve;
    bit          m_last_mdu;
    bit          e_we, e_after_rst;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          h1, h2;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock edge applied to the abstract queue state
    function automatic void model_edge();
        bit   nonempty, pipe_win, popped, take_mdu, mdu_acc, aes_acc;
        ent_t e;
        if (!nrst) begin
            mq.delete();
            aq.delete();
            m_pend = '0;
            m_starve = 0;
            m_last_mdu = 1'b0;
            e_we = 1'b0;
            e_addr = '0;
            e_data = '0;
            e_after_rst = 1'b1;
            return;
        end
        e_after_rst = 1'b0;
        nonempty = (mq.size() > 0) || (aq.size() > 0);
        pipe_win = pipe_we && (pipe_rd != 5'd0);
        mdu_acc  = mdu_valid && (mq.size() < DEPTH);
        aes_acc  = aes_valid && (aq.size() < DEPTH);
        popped   = 1'b0;
        e_we     = 1'b0;
        if (pipe_win) begin
            e_we = 1'b1;
            e_addr = pipe_rd;
            e_data = pipe_data;
        end else if (nonempty) begin
            take_mdu = (mq.size() > 0) && ((aq.size() == 0) || !m_last_mdu);
            if (take_mdu) e = mq.pop_front();
            else          e = aq.pop_front();
            m_last_mdu = take_mdu;
            popped = 1'b1;
            if (e.rd != 5'd0) begin
                e_we = 1'b1;
                e_addr = e.rd;
                e_data = e.data;
                m_pend[e.rd] = 1'b0;
            end
        end
        if (mdu_acc) mq.push_back('{mdu_rd, mdu_data});
        if (aes_acc) aq.push_back('{aes_rd, aes_data});
        if (issue_set && (issue_rd != 5'd0)) m_pend[issue_rd] = 1'b1;
        if (popped || !nonempty) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
    endfunction

    // Inputs are set at the falling edge; this checks one full cycle
    task automatic step();
        bit exp_hold;
        #1;
        exp_hold = (m_starve >= LIMIT);
        check("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
        check("aes_ready", 32'(aes_ready), 32'(aq.size() < DEPTH));
        check("rs_hazard", 32'(rs_hazard), 32'(m_pend[rs1] | m_pend[rs2]));
        check("hold_pipe", 32'(hold_pipe), 32'(exp_hold));
        h2 = h1;
        h1 = exp_hold;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we || e_after_rst) begin
            check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
            check("rf_wdata", rf_wdata, e_data);
        end
        check("pending", pending, m_pend);
    endtask

    task automatic idle();
        pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        aes_valid = 1'b0; aes_rd = '0; aes_data = '0;
        issue_set = 1'b0; issue_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
    endtask

    task automatic rand_inputs();
        pipe_we   = h2 ? 1'b0 : ($urandom_range(0, 1) == 1);
        pipe_rd   = 5'($urandom_range(0, 31));
        pipe_data = $urandom;
        mdu_valid = ($urandom_range(0, 2) == 0);
        mdu_rd    = 5'($urandom_range(0, 31));
        mdu_data  = $urandom;
        aes_valid = ($urandom_range(0, 3) == 0);
        aes_rd    = 5'($urandom_range(0, 31));
        aes_data  = $urandom;
        issue_set = ($urandom_range(0, 3) == 0);
        issue_rd  = 5'($urandom_range(0, 31));
        rs1       = 5'($urandom_range(0, 31));
        rs2       = 5'($urandom_range(0, 31));
        nrst      = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        h1 = 1'b0; h2 = 1'b0;
        idle();
        rs1 = '0; rs2 = '0;
        nrst = 1'b0;
        // Power-up reset: DUT state is unknown before this edge, so only outputs after it are checked
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        nrst = 1'b1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_pending", pending, 32'd0);

        // Pipeline write goes straight through
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        step();
        check("pipe_data", rf_wdata, 32'hDEADBEEF);
        idle();

        // Long-latency op on r7: hazard until its buffered write commits
        issue_set = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        step();
        idle();
        step();
        step();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12;
        step();
        idle();
        step();
        check("r7_addr", 32'(rf_waddr), 32'd7);
        check("r7_clear", 32'(pending[7]), 32'd0);
        rs1 = '0;

        // Round-robin between both buffers, twice
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h300 + 32'(k);
            aes_valid = 1'b1; aes_rd = 5'd4; aes_data = 32'h400 + 32'(k);
            step();
            idle();
            step();
            check("rr_first", 32'(rf_waddr), 32'd3);
            step();
            check("rr_second", 32'(rf_waddr), 32'd4);
        end

        // Starvation: pipeline busy, hold honoured two cycles later
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        step();
        mdu_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pipe_we = !h2;
            step();
        end
        idle();

        // Fill the mul/div buffer, push when full, then drain
        pipe_we = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h2;
        for (int c = 0; c < 3; c++) begin
            mdu_valid = 1'b1; mdu_rd = 5'd10 + 5'(c); mdu_data = 32'hA0 + 32'(c);
            step();
        end
        pipe_we = 1'b0;
        mdu_rd = 5'd13; mdu_data = 32'hA3;
        step();
        step();
        idle();
        repeat (3) step();

        // rd=0 entry is consumed silently; issue of rd=0 sets nothing
        aes_valid = 1'b1; aes_rd = 5'd0; aes_data = 32'hBAD;
        issue_set = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        step();
        check("rd0_no_we", 32'(rf_we), 32'd0);

        // Reset with both buffers full
        pipe_we = 1'b1; pipe_rd = 5'd6; pipe_data = 32'h6;
        for (int c = 0; c < 2; c++) begin
            mdu_valid = 1'b1; mdu_rd = 5'd20 + 5'(c); mdu_data = $urandom;
            aes_valid = 1'b1; aes_rd = 5'd24 + 5'(c); aes_data = $urandom;
            issue_set = 1'b1; issue_rd = 5'd20 + 5'(c);
            step();
        end
        do_reset();
        check("rst2_pending", pending, 32'd0);
        idle();
        step();
        check("rst2_ready", 32'({mdu_ready, aes_ready}), 32'd3);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
